// File: rtl/bus_responder_pkg.sv
// Shared CPU bus constants, MMIO register map and address decode for bus_responder.
// Status bit positions live here so firmware headers and RTL agree.
package bus_responder_pkg;

   localparam int unsigned CPU_DATA_W = 16;
   localparam int unsigned CPU_ADDR_W = 32;
   localparam int unsigned TX_BYTE_W  = 8;
   localparam int unsigned TIMER_W    = 32;

   // Addresses at or above this bit must be zero for a RAM hit.
   localparam int unsigned RAM_REGION_BITS = 16;

   localparam logic [31:0] MMIO_TX_DATA   = 32'hFFFF_0000;
   localparam logic [31:0] MMIO_TX_STATUS = 32'hFFFF_0001;
   localparam logic [31:0] MMIO_TIMER_LO  = 32'hFFFF_0002;
   localparam logic [31:0] MMIO_TIMER_HI  = 32'hFFFF_0003;

   localparam int unsigned STAT_EMPTY_BIT = 0;
   localparam int unsigned STAT_FULL_BIT  = 1;
   localparam int unsigned STAT_OVF_BIT   = 2;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_TX_DATA,
      SEL_TX_STATUS,
      SEL_TIMER_LO,
      SEL_TIMER_HI
   } sel_e;

   // Callers zero-extend their address to 64 bits so any bus width decodes the same way.
   function automatic sel_e decode_addr(input logic [63:0] addr);
      sel_e sel;
      sel = SEL_NONE;
      if (addr[63:RAM_REGION_BITS] == '0)                sel = SEL_RAM;
      else if (addr == {32'h0, MMIO_TX_DATA})            sel = SEL_TX_DATA;
      else if (addr == {32'h0, MMIO_TX_STATUS})          sel = SEL_TX_STATUS;
      else if (addr == {32'h0, MMIO_TIMER_LO})           sel = SEL_TIMER_LO;
      else if (addr == {32'h0, MMIO_TIMER_HI})           sel = SEL_TIMER_HI;
      return sel;
   endfunction

endpackage

// File: rtl/bus_responder_tx_fifo.sv
// Byte-wide TX FIFO with power-of-two depth; pointers carry one extra wrap bit.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module tx_fifo
   import bus_responder_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [TX_BYTE_W-1:0] pushData,
   input  logic                 pop,
   output logic [TX_BYTE_W-1:0] popData,
   output logic                 full,
   output logic                 empty
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);

   logic [TX_BYTE_W-1:0] r_mem [FIFO_DEPTH];
   logic [PW:0]          r_wr_ptr;
   logic [PW:0]          r_rd_ptr;
   logic                 w_do_push;
   logic                 w_do_pop;

   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                  (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);

   // Head is forced to zero when empty so stale storage never shows after reset.
   assign popData = empty ? '0 : r_mem[r_rd_ptr[PW-1:0]];

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[PW-1:0]] <= pushData;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/bus_responder.sv
// Single-cycle CPU bus slave: word RAM, TX byte FIFO with sticky overflow, and a
// free-running 32-bit timer whose high half is snapshotted on each low-half read.
module bus_responder
   import bus_responder_pkg::*;
#(
   parameter int unsigned M          = CPU_DATA_W,
   parameter int unsigned N          = CPU_ADDR_W,
   parameter int unsigned RAM_AW     = 16,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] memAddr,
   input  logic [M-1:0] memWrite,
   output logic [M-1:0] memRead,
   input  logic         memRE,
   input  logic         memWE,
   output logic [7:0]   txData,
   output logic         txValid,
   input  logic         txReady
);

   logic [M-1:0]         r_ram [2**RAM_AW];
   logic [TIMER_W-1:0]   r_count;
   logic [15:0]          r_snap;
   logic                 r_ovf;

   sel_e                 w_sel;
   logic [RAM_AW-1:0]    w_ram_idx;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_ovf_set;
   logic                 w_ovf_clr;
   logic                 w_timer_clr;
   logic                 w_snap_en;
   logic [15:0]          w_status;
   logic [M-1:0]         w_rdata;

   assign w_sel     = decode_addr(64'(memAddr));
   assign w_ram_idx = memAddr[RAM_AW-1:0];

   assign w_push      = memWE & (w_sel == SEL_TX_DATA);
   assign w_ovf_clr   = memWE & (w_sel == SEL_TX_STATUS);
   assign w_timer_clr = memWE & (w_sel == SEL_TIMER_LO);
   assign w_snap_en   = memRE & (w_sel == SEL_TIMER_LO);

   assign txValid   = ~w_empty;
   assign w_pop     = txValid & txReady;
   // A pop in the same cycle frees the slot, so only an unmatched push overflows.
   assign w_ovf_set = w_push & w_full & ~w_pop;

   tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (w_push),
      .pushData (memWrite[7:0]),
      .pop      (w_pop),
      .popData  (txData),
      .full     (w_full),
      .empty    (w_empty)
   );

   // RAM is deliberately left out of reset so its contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (memWE && (w_sel == SEL_RAM)) begin
         r_ram[w_ram_idx] <= memWrite;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
         r_snap  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_timer_clr) r_count <= '0;
         else             r_count <= r_count + 1'b1;

         if (w_snap_en) r_snap <= r_count[31:16];

         if (w_ovf_clr)      r_ovf <= 1'b0;
         else if (w_ovf_set) r_ovf <= 1'b1;
      end
   end

   always_comb begin
      w_status                 = '0;
      w_status[STAT_EMPTY_BIT] = w_empty;
      w_status[STAT_FULL_BIT]  = w_full;
      w_status[STAT_OVF_BIT]   = r_ovf;
   end

   always_comb begin
      w_rdata = '0;
      if (memRE) begin
         case (w_sel)
            SEL_RAM:       w_rdata = r_ram[w_ram_idx];
            SEL_TX_STATUS: w_rdata = M'(w_status);
            SEL_TIMER_LO:  w_rdata = M'(r_count[15:0]);
            SEL_TIMER_HI:  w_rdata = M'(r_snap);
            default:       w_rdata = '0;
         endcase
      end
   end

   assign memRead = w_rdata;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: direct bus read checks plus a TX byte
// scoreboard fed on pushes and drained when the DUT pops.
module tb_bus_responder;

   localparam int DEPTH = 8;
   localparam logic [31:0] A_TXD  = 32'hFFFF_0000;
   localparam logic [31:0] A_STAT = 32'hFFFF_0001;
   localparam logic [31:0] A_LO   = 32'hFFFF_0002;
   localparam logic [31:0] A_HI   = 32'hFFFF_0003;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] memAddr = '0;
   logic [15:0] memWrite = '0;
   logic [15:0] memRead;
   logic        memRE = 1'b0;
   logic        memWE = 1'b0;
   logic [7:0]  txData;
   logic        txValid;
   logic        txReady = 1'b0;

   int          n_total = 0;
   int          n_bad = 0;
   logic [7:0]  exp_q [$];
   logic        m_ovf = 1'b0;

   always #5 clk = ~clk;

   bus_responder #(
      .M          (16),
      .N          (32),
      .RAM_AW     (16),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .memAddr  (memAddr),
      .memWrite (memWrite),
      .memRead  (memRead),
      .memRE    (memRE),
      .memWE    (memWE),
      .txData   (txData),
      .txValid  (txValid),
      .txReady  (txReady)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: decides each edge what the FIFO must do, from the bench's own stimulus.
   always @(negedge clk) begin
      logic pop_m;
      if (!rst) begin
         exp_q.delete();
         m_ovf = 1'b0;
      end else begin
         check("txValid", 32'(txValid), 32'(exp_q.size() != 0));
         pop_m = txReady && (exp_q.size() != 0);
         if (pop_m) check("txData", 32'(txData), 32'(exp_q.pop_front()));
         if (memWE && memAddr == A_TXD) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(memWrite[7:0]);
            else                       m_ovf = 1'b1;
         end
         if (memWE && memAddr == A_STAT) m_ovf = 1'b0;
      end
   end

   task automatic bus(input logic [31:0] a, input logic re, input logic we,
                      input logic [15:0] wd, input logic chk, input logic [15:0] exp,
                      input string tag);
      memAddr  = a;
      memRE    = re;
      memWE    = we;
      memWrite = wd;
      @(negedge clk);
      if (chk) check(tag, 32'(memRead), 32'(exp));
      @(posedge clk);
      #1;
      memRE = 1'b0;
      memWE = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [15:0] wd);
      bus(a, 1'b0, 1'b1, wd, 1'b0, 16'h0, "wr");
   endtask

   task automatic rd(input logic [31:0] a, input logic [15:0] exp, input string tag);
      bus(a, 1'b1, 1'b0, 16'h0, 1'b1, exp, tag);
   endtask

   task automatic idle(input int n);
      memRE = 1'b0;
      memWE = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] model_status();
      return {13'b0, m_ovf, exp_q.size() == DEPTH, exp_q.size() == 0};
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_txValid", 32'(txValid), 32'd0);
      check("rst_txData", 32'(txData), 32'd0);
      memRE   = 1'b1;
      memAddr = A_STAT;
      #1 check("rst_status", 32'(memRead), 32'd1);
      memAddr = A_LO;
      #1 check("rst_timer", 32'(memRead), 32'd0);
      memRE = 1'b0;
      rst   = 1'b1;
      rd(A_LO, 16'd0, "timer_first");
      rd(A_LO, 16'd1, "timer_second");

      wr(32'h10, 16'h1234);
      rd(32'h10, 16'h1234, "ram_rd");
      rd(32'h0002_0000, 16'h0, "unmapped_hi");
      rd(32'h1234_5678, 16'h0, "unmapped");
      bus(32'h10, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0, "re_low");
      wr(32'h0, 16'h0F0F);
      wr(32'h0002_0000, 16'hDEAD);
      rd(32'h0, 16'h0F0F, "no_alias_wr");
      wr(32'h3, 16'h3333);
      wr(A_HI, 16'h9999);
      rd(32'h3, 16'h3333, "mmio_ram_iso");
      rd(A_TXD, 16'h0, "txdata_rd");

      wr(32'h20, 16'hAAAA);
      bus(32'h20, 1'b1, 1'b1, 16'hBBBB, 1'b1, 16'hAAAA, "rw_old");
      rd(32'h20, 16'hBBBB, "rw_new");

      txReady = 1'b0;
      for (int i = 0; i < 9; i++) wr(A_TXD, 16'h41 + 16'(i));
      rd(A_STAT, 16'h0006, "ovf_status");
      txReady = 1'b1;
      idle(12);
      rd(A_STAT, 16'h0005, "drained_ovf");
      wr(A_STAT, 16'h0);
      rd(A_STAT, model_status(), "ovf_clr");

      txReady = 1'b0;
      for (int i = 0; i < DEPTH; i++) wr(A_TXD, 16'h60 + 16'(i));
      rd(A_STAT, 16'h0002, "full_status");
      txReady = 1'b1;
      wr(A_TXD, 16'h55);
      rd(A_STAT, 16'h0002, "push_pop_full");
      idle(12);
      rd(A_STAT, 16'h0001, "drained2");

      wr(A_TXD, 16'h77);
      idle(3);

      txReady = 1'b0;
      wr(A_TXD, 16'h31);
      wr(A_TXD, 16'h32);
      wr(A_TXD, 16'h33);
      #3 rst = 1'b0;
      #1;
      check("async_txValid", 32'(txValid), 32'd0);
      check("async_txData", 32'(txData), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      rd(A_STAT, 16'h0001, "post_rst_status");
      rd(32'h10, 16'h1234, "ram_kept1");
      rd(32'h20, 16'hBBBB, "ram_kept2");

      wr(A_LO, 16'h0);
      idle(65534);
      rd(A_LO, 16'hFFFE, "lo_near_carry");
      idle(5);
      rd(A_HI, 16'h0000, "hi_snapshot");
      rd(A_LO, 16'h0005, "lo_after_carry");
      rd(A_HI, 16'h0001, "hi_snapshot2");
      wr(A_HI, 16'h7777);
      rd(A_HI, 16'h0001, "hi_wr_ignored");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
